// File: rtl/packet_buffer_pkg.sv
// rtl/packet_buffer_pkg.sv - shared L2 parser types and Ethernet constants
package packet_buffer_pkg;

  localparam logic [15:0] ETHERTYPE_VLAN    = 16'h8100;
  localparam int          ETH_L2_BYTES      = 14;
  localparam int          ETH_L2_VLAN_BYTES = 18;

  typedef enum logic [1:0] {
    ST_HDR  = 2'd0,
    ST_ETH  = 2'd1,
    ST_SKIP = 2'd2,
    ST_EMIT = 2'd3
  } parser_state_t;

  typedef struct packed {
    logic [47:0] dst_mac;
    logic [47:0] src_mac;
    logic [15:0] ethertype;
    logic        vlan_valid;
    logic [11:0] vlan_id;
    logic [15:0] frame_length;
    logic        runt;
    logic        oversize;
  } l2_record_t;

endpackage

// File: rtl/lane_frame_parser.sv
// rtl/lane_frame_parser.sv - per-lane header/L2 field extractor emitting one record per frame
module lane_frame_parser
  import packet_buffer_pkg::*;
#(
  parameter int DATA_WIDTH       = 8,
  parameter int HEADER_BYTES     = 8,
  parameter int LENGTH_OFFSET    = 0,
  parameter int MAX_FRAME_LENGTH = 1518
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [DATA_WIDTH-1:0] s_tdata_i,
  input  logic                  s_tvalid_i,
  output logic                  s_tready_o,
  output logic                  m_valid_o,
  input  logic                  m_ready_i,
  output logic [47:0]           m_dst_mac_o,
  output logic [47:0]           m_src_mac_o,
  output logic [15:0]           m_ethertype_o,
  output logic                  m_vlan_valid_o,
  output logic [11:0]           m_vlan_id_o,
  output logic [15:0]           m_frame_length_o,
  output logic                  m_runt_o,
  output logic                  m_oversize_o,
  output logic [31:0]           frame_count_o
);

  localparam int HDR_W = $clog2(HEADER_BYTES + 1);
  localparam logic [1:0] HDR  = ST_HDR;
  localparam logic [1:0] ETH  = ST_ETH;
  localparam logic [1:0] SKIP = ST_SKIP;
  localparam logic [1:0] EMIT = ST_EMIT;
  localparam logic [4:0] K_TYPE_LO  = 5'(ETH_L2_BYTES - 1);
  localparam logic [4:0] K_INNER_LO = 5'(ETH_L2_VLAN_BYTES - 1);

  logic [1:0]       state_q;
  logic [HDR_W-1:0] hdr_cnt_q;
  logic [15:0]      byte_cnt_q;
  logic [7:0]       len_hi_q, len_lo_q, inner_hi_q;
  logic             ready_en_q;
  logic [31:0]      frame_count_q;
  l2_record_t       rec_q;

  logic [7:0]  b;
  logic        accept, hdr_last, frame_last, k_small, eth_done;
  logic [15:0] len_now, cnt_inc;
  logic [4:0]  k5;
  logic [2:0]  dst_sel, src_sel;

  always_comb begin
    b          = s_tdata_i[7:0];
    accept     = s_tvalid_i && s_tready_o;
    hdr_last   = (hdr_cnt_q == HDR_W'(HEADER_BYTES - 1));
    len_now    = {len_hi_q, (hdr_cnt_q == HDR_W'(LENGTH_OFFSET + 1)) ? b : len_lo_q};
    cnt_inc    = byte_cnt_q + 16'd1;
    frame_last = (cnt_inc == rec_q.frame_length);
    k5         = byte_cnt_q[4:0];
    k_small    = (byte_cnt_q < 16'(ETH_L2_VLAN_BYTES));
    dst_sel    = 3'(5'd5 - k5);
    src_sel    = 3'(5'd11 - k5);
    // The tag decision is made on the byte that completes the outer ethertype.
    eth_done   = k_small &&
                 ((k5 == K_TYPE_LO && {rec_q.ethertype[15:8], b} != ETHERTYPE_VLAN) ||
                  (k5 == K_INNER_LO && rec_q.vlan_valid));
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= HDR;
      hdr_cnt_q     <= '0;
      byte_cnt_q    <= '0;
      len_hi_q      <= '0;
      len_lo_q      <= '0;
      inner_hi_q    <= '0;
      ready_en_q    <= 1'b0;
      frame_count_q <= '0;
      rec_q         <= '0;
    end else begin
      ready_en_q <= 1'b1;
      case (state_q)
        HDR: if (accept) begin
          if (hdr_cnt_q == HDR_W'(LENGTH_OFFSET))     len_hi_q <= b;
          if (hdr_cnt_q == HDR_W'(LENGTH_OFFSET + 1)) len_lo_q <= b;
          if (hdr_last) begin
            hdr_cnt_q          <= '0;
            byte_cnt_q         <= '0;
            rec_q              <= '0;
            rec_q.frame_length <= len_now;
            rec_q.oversize     <= (len_now > 16'(MAX_FRAME_LENGTH));
            if (len_now == 16'd0) begin
              rec_q.runt <= 1'b1;
              state_q    <= EMIT;
            end else begin
              state_q <= ETH;
            end
          end else begin
            hdr_cnt_q <= hdr_cnt_q + 1'b1;
          end
        end
        ETH: if (accept) begin
          byte_cnt_q <= cnt_inc;
          if (k_small) begin
            if (k5 < 5'd6)       rec_q.dst_mac[{dst_sel, 3'b000} +: 8] <= b;
            else if (k5 < 5'd12) rec_q.src_mac[{src_sel, 3'b000} +: 8] <= b;
            else begin
              case (k5)
                5'd12: rec_q.ethertype[15:8] <= b;
                5'd13: begin
                  rec_q.ethertype[7:0] <= b;
                  if ({rec_q.ethertype[15:8], b} == ETHERTYPE_VLAN) rec_q.vlan_valid <= 1'b1;
                end
                5'd14: if (rec_q.vlan_valid) rec_q.vlan_id[11:8] <= b[3:0];
                5'd15: if (rec_q.vlan_valid) rec_q.vlan_id[7:0]  <= b;
                5'd16: if (rec_q.vlan_valid) inner_hi_q <= b;
                5'd17: if (rec_q.vlan_valid) rec_q.ethertype <= {inner_hi_q, b};
                default: ;
              endcase
            end
          end
          // Frame end wins over field capture: an early end marks the record a runt.
          if (frame_last) begin
            rec_q.runt <= !eth_done;
            state_q    <= EMIT;
          end else if (eth_done) begin
            state_q <= SKIP;
          end
        end
        SKIP: if (accept) begin
          byte_cnt_q <= cnt_inc;
          if (frame_last) state_q <= EMIT;
        end
        EMIT: if (m_ready_i) begin
          state_q       <= HDR;
          frame_count_q <= frame_count_q + 32'd1;
        end
        default: state_q <= HDR;
      endcase
    end
  end

  assign s_tready_o       = ready_en_q && (state_q != EMIT);
  assign m_valid_o        = (state_q == EMIT);
  assign m_dst_mac_o      = rec_q.dst_mac;
  assign m_src_mac_o      = rec_q.src_mac;
  assign m_ethertype_o    = rec_q.ethertype;
  assign m_vlan_valid_o   = rec_q.vlan_valid;
  assign m_vlan_id_o      = rec_q.vlan_id;
  assign m_frame_length_o = rec_q.frame_length;
  assign m_runt_o         = rec_q.runt;
  assign m_oversize_o     = rec_q.oversize;
  assign frame_count_o    = frame_count_q;

endmodule

// File: tb/tb_lane_frame_parser.sv
// tb/tb_lane_frame_parser.sv - table-driven scoreboard bench for lane_frame_parser
module tb_lane_frame_parser;

  typedef struct {
    int          len;
    logic [47:0] dst, src;
    logic [15:0] etype, tci, inner;
    logic [47:0] e_dst, e_src;
    logic [15:0] e_type;
    logic        e_vv;
    logic [11:0] e_vid;
    logic        e_runt, e_over;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  s_tdata = '0;
  logic        s_tvalid = 1'b0;
  logic        s_tready_o;
  logic        m_valid_o;
  logic        m_ready = 1'b1;
  logic [47:0] m_dst_mac_o, m_src_mac_o;
  logic [15:0] m_ethertype_o, m_frame_length_o;
  logic        m_vlan_valid_o, m_runt_o, m_oversize_o;
  logic [11:0] m_vlan_id_o;
  logic [31:0] frame_count_o;

  vec_t tbl[10];
  vec_t q[$];
  int   n_checks = 0;
  int   n_fail = 0;
  int   exp_count = 0;

  always #5 clk = ~clk;

  lane_frame_parser dut (
    .clk_i(clk), .rst_ni(rst_n),
    .s_tdata_i(s_tdata), .s_tvalid_i(s_tvalid), .s_tready_o(s_tready_o),
    .m_valid_o(m_valid_o), .m_ready_i(m_ready),
    .m_dst_mac_o(m_dst_mac_o), .m_src_mac_o(m_src_mac_o),
    .m_ethertype_o(m_ethertype_o), .m_vlan_valid_o(m_vlan_valid_o),
    .m_vlan_id_o(m_vlan_id_o), .m_frame_length_o(m_frame_length_o),
    .m_runt_o(m_runt_o), .m_oversize_o(m_oversize_o),
    .frame_count_o(frame_count_o)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input int len, input logic [15:0] et, input logic [47:0] e_dst,
                              input logic [47:0] e_src, input logic [15:0] e_type, input logic e_vv,
                              input logic [11:0] e_vid, input logic e_runt, input logic e_over);
    vec_t v;
    v.len = len; v.dst = 48'h010203040506; v.src = 48'h0A0B0C0D0E0F;
    v.etype = et; v.tci = 16'h2064; v.inner = 16'h86DD;
    v.e_dst = e_dst; v.e_src = e_src; v.e_type = e_type; v.e_vv = e_vv;
    v.e_vid = e_vid; v.e_runt = e_runt; v.e_over = e_over;
    return v;
  endfunction

  function automatic logic [7:0] hbyte(input int idx, input int n);
    logic [15:0] l;
    l = 16'(tbl[idx].len);
    if (n == 0) return l[15:8];
    if (n == 1) return l[7:0];
    return 8'(8'hA0 + n);
  endfunction

  function automatic logic [7:0] fbyte(input int idx, input int k);
    vec_t v;
    v = tbl[idx];
    if (k < 6)  return v.dst[8*(5-k) +: 8];
    if (k < 12) return v.src[8*(11-k) +: 8];
    if (k == 12) return v.etype[15:8];
    if (k == 13) return v.etype[7:0];
    if (v.etype == 16'h8100 && k < 18) begin
      if (k == 14) return v.tci[15:8];
      if (k == 15) return v.tci[7:0];
      if (k == 16) return v.inner[15:8];
      return v.inner[7:0];
    end
    return 8'(k * 7 + 3);
  endfunction

  // Drives header+frame bytes from negedge to negedge; max_bytes < 0 sends the whole frame.
  task automatic send_frame(input int idx, input bit gaps, input int max_bytes, input bit push);
    int total;
    int wait_cnt;
    total = 8 + tbl[idx].len;
    if (max_bytes >= 0 && max_bytes < total) total = max_bytes;
    if (push) q.push_back(tbl[idx]);
    for (int n = 0; n < total; n++) begin
      if (gaps && $urandom_range(0, 2) == 0) begin
        s_tvalid = 1'b0;
        repeat ($urandom_range(1, 3)) @(negedge clk);
      end
      s_tdata  = (n < 8) ? hbyte(idx, n) : fbyte(idx, n - 8);
      s_tvalid = 1'b1;
      wait_cnt = 0;
      while (!s_tready_o && wait_cnt < 200) begin
        @(negedge clk);
        wait_cnt++;
      end
      if (!s_tready_o) begin
        chk("accept_timeout", 64'd0, 64'd1);
        s_tvalid = 1'b0;
        return;
      end
      @(negedge clk);
    end
    s_tvalid = 1'b0;
  endtask

  task automatic drain();
    int c;
    c = 0;
    while (q.size() != 0 && c < 100) begin
      @(negedge clk);
      c++;
    end
    chk("drain_empty", 64'(q.size()), 64'd0);
  endtask

  always @(negedge clk) begin
    if (rst_n && m_valid_o && m_ready) begin
      if (q.size() == 0) begin
        chk("unexpected_record", 64'd1, 64'd0);
      end else begin
        vec_t e;
        e = q.pop_front();
        chk("dst_mac", 64'(m_dst_mac_o), 64'(e.e_dst));
        chk("src_mac", 64'(m_src_mac_o), 64'(e.e_src));
        chk("ethertype", 64'(m_ethertype_o), 64'(e.e_type));
        chk("vlan_valid", 64'(m_vlan_valid_o), 64'(e.e_vv));
        chk("vlan_id", 64'(m_vlan_id_o), 64'(e.e_vid));
        chk("frame_length", 64'(m_frame_length_o), 64'(e.len));
        chk("runt", 64'(m_runt_o), 64'(e.e_runt));
        chk("oversize", 64'(m_oversize_o), 64'(e.e_over));
        chk("frame_count", 64'(frame_count_o), 64'(exp_count));
        exp_count++;
      end
    end
  end

  initial begin
    tbl[0] = mk(64,   16'h0800, 48'h010203040506, 48'h0A0B0C0D0E0F, 16'h0800, 0, 12'h000, 0, 0);
    tbl[1] = mk(68,   16'h8100, 48'h010203040506, 48'h0A0B0C0D0E0F, 16'h86DD, 1, 12'h064, 0, 0);
    tbl[2] = mk(10,   16'h0800, 48'h010203040506, 48'h0A0B0C0D0000, 16'h0000, 0, 12'h000, 1, 0);
    tbl[3] = mk(0,    16'h0800, 48'h0,            48'h0,            16'h0000, 0, 12'h000, 1, 0);
    tbl[4] = mk(1600, 16'h0800, 48'h010203040506, 48'h0A0B0C0D0E0F, 16'h0800, 0, 12'h000, 0, 1);
    tbl[5] = mk(14,   16'h0800, 48'h010203040506, 48'h0A0B0C0D0E0F, 16'h0800, 0, 12'h000, 0, 0);
    tbl[6] = mk(18,   16'h8100, 48'h010203040506, 48'h0A0B0C0D0E0F, 16'h86DD, 1, 12'h064, 0, 0);
    tbl[7] = mk(1518, 16'h0800, 48'h010203040506, 48'h0A0B0C0D0E0F, 16'h0800, 0, 12'h000, 0, 0);
    tbl[8] = mk(1519, 16'h0800, 48'h010203040506, 48'h0A0B0C0D0E0F, 16'h0800, 0, 12'h000, 0, 1);
    tbl[9] = mk(1,    16'h0800, 48'h010000000000, 48'h0,            16'h0000, 0, 12'h000, 1, 0);

    repeat (2) @(negedge clk);
    chk("rst_tready", 64'(s_tready_o), 64'd0);
    chk("rst_valid", 64'(m_valid_o), 64'd0);
    chk("rst_count", 64'(frame_count_o), 64'd0);
    chk("rst_dst", 64'(m_dst_mac_o), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("tready_after_release", 64'(s_tready_o), 64'd1);

    // Valid must already be high at the negedge following the last accepted byte.
    send_frame(0, 0, -1, 1);
    chk("latency_untagged", 64'(m_valid_o), 64'd1);
    repeat (2) @(negedge clk);
    chk("count_after_first", 64'(frame_count_o), 64'd1);

    for (int i = 1; i < 10; i++) begin
      send_frame(i, 0, -1, 1);
      chk($sformatf("latency_vec%0d", i), 64'(m_valid_o), 64'd1);
    end
    drain();

    m_ready = 1'b0;
    send_frame(1, 0, -1, 1);
    for (int c = 0; c < 20; c++) begin
      chk("bp_valid", 64'(m_valid_o), 64'd1);
      chk("bp_tready", 64'(s_tready_o), 64'd0);
      chk("bp_vlan_id", 64'(m_vlan_id_o), 64'(tbl[1].e_vid));
      chk("bp_ethertype", 64'(m_ethertype_o), 64'(tbl[1].e_type));
      @(negedge clk);
    end
    chk("bp_count_held", 64'(frame_count_o), 64'(exp_count));
    m_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("bp_count_once", 64'(frame_count_o), 64'(exp_count));
    chk("bp_valid_drop", 64'(m_valid_o), 64'd0);

    for (int r = 0; r < 3; r++) begin
      send_frame(0, 1, -1, 1);
      send_frame(1, 1, -1, 1);
      send_frame(2, 1, -1, 1);
    end
    drain();

    send_frame(4, 0, 48, 0);
    rst_n = 1'b0;
    #1;
    chk("midframe_rst_valid", 64'(m_valid_o), 64'd0);
    chk("midframe_rst_count", 64'(frame_count_o), 64'd0);
    chk("midframe_rst_tready", 64'(s_tready_o), 64'd0);
    exp_count = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    send_frame(1, 0, -1, 1);
    drain();
    @(negedge clk);
    chk("post_rst_count", 64'(frame_count_o), 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
